// File: rtl/led_arb_pkg.sv
// Shared constants and the blink-pattern decode for the status LED arbiter.
package led_arb_pkg;

  localparam int PHASE_W = 3;

  localparam logic [1:0] LED_SOLID  = 2'd0;
  localparam logic [1:0] LED_SLOW   = 2'd1;
  localparam logic [1:0] LED_FAST   = 2'd2;
  localparam logic [1:0] LED_DOUBLE = 2'd3;

  // True when a lamp in the given mode is lit at the given pattern phase.
  function automatic logic pattern_on(input logic [1:0] mode,
                                      input logic [PHASE_W-1:0] phase);
    logic on;
    on = 1'b1;
    case (mode)
      LED_SOLID:  on = 1'b1;
      LED_SLOW:   on = ~phase[2];
      LED_FAST:   on = ~phase[0];
      LED_DOUBLE: on = (phase == 3'd0) || (phase == 3'd2);
      default:    on = 1'b1;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern timebase: a prescaler producing one tick every TICK_DIV cycles and an
// eight-step phase counter, both restartable so a new owner starts at phase 0.
module led_tick_gen
  import led_arb_pkg::*;
#(
  parameter int TICK_DIV = 20000000
) (
  input  logic               clk_200,
  input  logic               reset,
  input  logic               restart,
  output logic               tick_stb,
  output logic [PHASE_W-1:0] phase
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] prescaler;

  assign tick_stb = (prescaler == LAST);

  // A restart outranks a coincident tick, so phase lands on 0 rather than 1.
  always_ff @(posedge clk_200) begin
    if (reset || restart) begin
      prescaler <= '0;
      phase     <= '0;
    end else if (tick_stb) begin
      prescaler <= '0;
      phase     <= phase + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority owner selection for the shared tri-color status LED, with
// per-owner blink rendering and a lamp-test override.
module led_status_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 20000000
) (
  input  logic               clk_200,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_color,
  input  logic [2*N_REQ-1:0] req_mode,
  input  logic               lamp_test,
  output logic               led_red,
  output logic               led_green,
  output logic               led_blue,
  output logic               grant_valid,
  output logic [2:0]         grant_idx
);

  logic               any_req;
  logic [2:0]         winner;
  logic [2:0]         win_color;
  logic [1:0]         win_mode;
  logic               regrant;
  logic [2:0]         color_q;
  logic [1:0]         mode_q;
  logic               tick_stb;
  logic [PHASE_W-1:0] phase;
  logic               led_on;

  // Ascending scan so the highest active index is the one left standing.
  always_comb begin
    any_req   = 1'b0;
    winner    = '0;
    win_color = '0;
    win_mode  = LED_SOLID;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        any_req   = 1'b1;
        winner    = 3'(i);
        win_color = req_color[3*i +: 3];
        win_mode  = req_mode[2*i +: 2];
      end
    end
  end

  assign regrant = (any_req != grant_valid) || (any_req && (winner != grant_idx));

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_200  (clk_200),
    .reset    (reset),
    .restart  (regrant),
    .tick_stb (tick_stb),
    .phase    (phase)
  );

  // Color and mode are captured only on a change of owner; later edits by the
  // same owner wait for the next regrant.
  always_ff @(posedge clk_200) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      color_q     <= '0;
      mode_q      <= LED_SOLID;
    end else if (regrant) begin
      grant_valid <= any_req;
      grant_idx   <= winner;
      color_q     <= win_color;
      mode_q      <= win_mode;
    end
  end

  assign led_on = grant_valid && pattern_on(mode_q, phase);

  always_ff @(posedge clk_200) begin
    if (reset) begin
      {led_red, led_green, led_blue} <= 3'b000;
    end else if (lamp_test) begin
      {led_red, led_green, led_blue} <= 3'b111;
    end else begin
      {led_red, led_green, led_blue} <= led_on ? color_q : 3'b000;
    end
  end

  // A tick without a restart must advance the phase by exactly one step.
  assert property (@(posedge clk_200) disable iff (reset)
                   (tick_stb && !regrant) |=> (phase == $past(phase) + 3'd1));

endmodule

// File: tb/tb_led_status_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a cycle-count based reference model of the LED arbiter.
module tb_led_status_arbiter;

  localparam int N_REQ    = 4;
  localparam int TICK_DIV = 4;

  logic               clk_200 = 1'b0;
  logic               reset;
  logic [N_REQ-1:0]   req;
  logic [3*N_REQ-1:0] req_color;
  logic [2*N_REQ-1:0] req_mode;
  logic               lamp_test;
  logic               led_red, led_green, led_blue;
  logic               grant_valid;
  logic [2:0]         grant_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: owner, its captured look, and cycles since the last restart.
  bit       m_valid;
  int       m_idx;
  logic [2:0] m_color;
  int       m_mode;
  int       m_t;
  logic [2:0] m_led;

  always #5 clk_200 = ~clk_200;

  led_status_arbiter #(
    .N_REQ    (N_REQ),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_200     (clk_200),
    .reset       (reset),
    .req         (req),
    .req_color   (req_color),
    .req_mode    (req_mode),
    .lamp_test   (lamp_test),
    .led_red     (led_red),
    .led_green   (led_green),
    .led_blue    (led_blue),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic bit model_on(input int mode, input int phase);
    case (mode)
      0:       return 1'b1;
      1:       return phase < 4;
      2:       return (phase % 2) == 0;
      default: return (phase == 0) || (phase == 2);
    endcase
  endfunction

  task automatic modelUpdate();
    int winner;
    int phase;
    winner = -1;
    for (int i = 0; i < N_REQ; i++)
      if (req[i]) winner = i;
    if (reset) begin
      m_valid = 0; m_idx = 0; m_color = 3'b000; m_mode = 0; m_t = 0; m_led = 3'b000;
    end else begin
      phase = (m_t / TICK_DIV) % 8;
      if (lamp_test) m_led = 3'b111;
      else if (m_valid && model_on(m_mode, phase)) m_led = m_color;
      else m_led = 3'b000;
      if (winner >= 0 && (!m_valid || winner != m_idx)) begin
        m_valid = 1;
        m_idx   = winner;
        m_color = req_color[3*winner +: 3];
        m_mode  = int'(req_mode[2*winner +: 2]);
        m_t     = 0;
      end else if (winner < 0 && m_valid) begin
        m_valid = 0;
        m_idx   = 0;
        m_t     = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_200);
    modelUpdate();
    @(negedge clk_200);
    checkOutput("led_rgb", {5'b0, led_red, led_green, led_blue}, {5'b0, m_led});
    checkOutput("grant_valid", {7'b0, grant_valid}, {7'b0, m_valid});
    checkOutput("grant_idx", {5'b0, grant_idx}, 8'(m_idx));
  endtask

  task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] r,
                               input logic [3*N_REQ-1:0] c, input logic [2*N_REQ-1:0] m,
                               input logic lt, input int cycles);
    reset     = rst;
    req       = r;
    req_color = c;
    req_mode  = m;
    lamp_test = lt;
    for (int k = 0; k < cycles; k++) step();
  endtask

  initial begin
    logic [N_REQ-1:0]   r;
    logic [3*N_REQ-1:0] c;
    logic [2*N_REQ-1:0] m;
    logic               lt;
    logic               rst;

    reset = 1'b1; req = '0; req_color = '0; req_mode = '0; lamp_test = 1'b0;

    applyStimulus(1'b1, 4'b1111, 12'o7531, 8'h1b, 1'b0, 3);
    applyStimulus(1'b0, 4'b1111, 12'o7531, 8'h1b, 1'b0, 2);
    checkOutput("grant_after_reset", {5'b0, grant_idx}, 8'd3);

    // Solid red on requester 0.
    applyStimulus(1'b0, 4'b0001, 12'o0004, 8'h00, 1'b0, 20);
    checkOutput("solid_red", {5'b0, led_red, led_green, led_blue}, 8'b100);

    // Slow green on requester 1: 16 on, 16 off.
    applyStimulus(1'b0, 4'b0010, 12'o0020, 8'h04, 1'b0, 70);

    // Preemption by fast blue on requester 3, then release back to solid red.
    applyStimulus(1'b0, 4'b0001, 12'o1004, 8'h80, 1'b0, 7);
    applyStimulus(1'b0, 4'b1001, 12'o1004, 8'h80, 1'b0, 20);
    applyStimulus(1'b0, 4'b0001, 12'o1004, 8'h80, 1'b0, 10);

    // Owner edits its color: ignored until a drop and re-raise.
    applyStimulus(1'b0, 4'b0001, 12'o1002, 8'h80, 1'b0, 10);
    checkOutput("color_edit_ignored", {5'b0, led_red, led_green, led_blue}, 8'b100);
    applyStimulus(1'b0, 4'b0000, 12'o1002, 8'h80, 1'b0, 1);
    applyStimulus(1'b0, 4'b0001, 12'o1002, 8'h80, 1'b0, 10);
    checkOutput("color_after_regrant", {5'b0, led_red, led_green, led_blue}, 8'b010);

    // Lamp test pulse during a double-blink owner.
    applyStimulus(1'b0, 4'b0100, 12'o0300, 8'h30, 1'b0, 7);
    applyStimulus(1'b0, 4'b0100, 12'o0300, 8'h30, 1'b1, 5);
    applyStimulus(1'b0, 4'b0100, 12'o0300, 8'h30, 1'b0, 30);

    // Reset in the middle of operation.
    applyStimulus(1'b1, 4'b0110, 12'o0330, 8'h34, 1'b0, 2);
    applyStimulus(1'b0, 4'b0110, 12'o0330, 8'h34, 1'b0, 10);

    // Random traffic in held segments so blink patterns have time to develop.
    r = 4'b0000;
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      else r = r ^ (4'b0001 << $urandom_range(0, 3));
      c   = 12'($urandom);
      m   = 8'($urandom);
      lt  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 29) == 0);
      applyStimulus(rst, r, c, m, lt, rst ? 1 : int'($urandom_range(1, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
